// File: rtl/fma16_pkg.sv
// Shared types and constants for the half-precision FMA request scheduler.
package fma16_pkg;

  // Field order matches the {mul, add, negp, negz} request encoding (mul is the MSB).
  typedef struct packed {
    logic mul;
    logic add;
    logic negp;
    logic negz;
  } fma_op_t;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [15:0] FP16_ONE = 16'h3C00;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (en && !found && req[j]) begin
        found      = 1'b1;
        gnt[j]     = 1'b1;
        gnt_idx    = j[IW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + IW'(1);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fma16_sched.sv
// Shares one combinational FP16 FMA datapath among NREQ requesters through a
// two-stage issue/result pipeline with per-requester sticky flag accumulation.
module fma16_sched
  import fma16_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*16-1:0] req_x,
  input  logic [NREQ*16-1:0] req_y,
  input  logic [NREQ*16-1:0] req_z,
  input  logic [NREQ*4-1:0]  req_op,
  input  logic [NREQ*2-1:0]  req_rm,
  output logic [15:0]        fma_x,
  output logic [15:0]        fma_y,
  output logic [15:0]        fma_z,
  output logic               fma_mul,
  output logic               fma_add,
  output logic               fma_negp,
  output logic               fma_negz,
  output logic [1:0]         fma_rm,
  input  logic [15:0]        fma_result,
  input  logic [3:0]         fma_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [15:0]        rsp_result,
  output logic [3:0]         rsp_flags,
  output logic [NREQ*4-1:0]  flags_acc,
  input  logic [NREQ-1:0]    flags_clr,
  output logic               busy
);

  logic             v1_q, v1_d, v2_q, v2_d;
  logic [IDW-1:0]   id1_q, id1_d, id2_q, id2_d;
  logic [15:0]      x1_q, x1_d, y1_q, y1_d, z1_q, z1_d, result2_q, result2_d;
  fma_op_t          op1_q, op1_d;
  logic [1:0]       rm1_q, rm1_d;
  logic [3:0]       flags2_q, flags2_d;
  logic [NREQ*4-1:0] flags_acc_q, flags_acc_d;

  logic             s1_free, s2_free, arb_en, hs;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;

  assign s2_free = ~v2_q | rsp_ready;
  assign s1_free = ~v1_q | s2_free;
  assign hs      = v2_q & rsp_ready;
  // Holding reset keeps req_ready low, so nobody believes a request was taken.
  assign arb_en  = s1_free & reset_n;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    v1_d  = v1_q;
    id1_d = id1_q;
    x1_d  = x1_q;
    y1_d  = y1_q;
    z1_d  = z1_q;
    op1_d = op1_q;
    rm1_d = rm1_q;
    if (s1_free) begin
      v1_d = |gnt;
      if (|gnt) begin
        id1_d = gnt_idx;
        x1_d  = req_x[16*gnt_idx +: 16];
        y1_d  = req_y[16*gnt_idx +: 16];
        z1_d  = req_z[16*gnt_idx +: 16];
        op1_d = fma_op_t'(req_op[4*gnt_idx +: 4]);
        rm1_d = req_rm[2*gnt_idx +: 2];
      end
    end
  end

  always_comb begin
    v2_d      = v2_q;
    id2_d     = id2_q;
    result2_d = result2_q;
    flags2_d  = flags2_q;
    if (v1_q && s2_free) begin
      v2_d      = 1'b1;
      id2_d     = id1_q;
      result2_d = fma_result;
      flags2_d  = fma_flags;
    end else if (s2_free && rsp_ready) begin
      v2_d = 1'b0;
    end
  end

  // Clear first, then OR in the delivered flags, so a same-cycle clear keeps the new ones.
  always_comb begin
    flags_acc_d = flags_acc_q;
    for (int i = 0; i < NREQ; i++) begin
      if (flags_clr[i]) flags_acc_d[4*i +: 4] = 4'b0;
      if (hs && id2_q == IDW'(i)) flags_acc_d[4*i +: 4] = flags_acc_d[4*i +: 4] | flags2_q;
    end
  end

  // NOTE: payload registers are reset too, so outputs read zero right after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q        <= 1'b0;
      id1_q       <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      z1_q        <= '0;
      op1_q       <= '0;
      rm1_q       <= '0;
      v2_q        <= 1'b0;
      id2_q       <= '0;
      result2_q   <= '0;
      flags2_q    <= '0;
      flags_acc_q <= '0;
    end else begin
      v1_q        <= v1_d;
      id1_q       <= id1_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      z1_q        <= z1_d;
      op1_q       <= op1_d;
      rm1_q       <= rm1_d;
      v2_q        <= v2_d;
      id2_q       <= id2_d;
      result2_q   <= result2_d;
      flags2_q    <= flags2_d;
      flags_acc_q <= flags_acc_d;
    end
  end

  assign req_ready  = gnt;
  assign fma_x      = v1_q ? x1_q : 16'h0;
  assign fma_y      = v1_q ? y1_q : 16'h0;
  assign fma_z      = v1_q ? z1_q : 16'h0;
  assign fma_mul    = v1_q & op1_q.mul;
  assign fma_add    = v1_q & op1_q.add;
  assign fma_negp   = v1_q & op1_q.negp;
  assign fma_negz   = v1_q & op1_q.negz;
  assign fma_rm     = v1_q ? rm1_q : 2'b0;
  assign rsp_valid  = v2_q;
  assign rsp_id     = id2_q;
  assign rsp_result = result2_q;
  assign rsp_flags  = flags2_q;
  assign flags_acc  = flags_acc_q;
  assign busy       = v1_q | v2_q;

endmodule

// File: tb/tb_fma16_sched.sv
// Directed bench for fma16_sched with a tiny stand-in datapath model.
module tb_fma16_sched;
  import fma16_pkg::*;

  localparam int NREQ = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [31:0] req_x = '0, req_y = '0, req_z = '0;
  logic [7:0]  req_op = '0;
  logic [3:0]  req_rm = '0;
  logic [15:0] fma_x, fma_y, fma_z;
  logic        fma_mul, fma_add, fma_negp, fma_negz;
  logic [1:0]  fma_rm;
  logic [15:0] fma_result;
  logic [3:0]  fma_flags;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [7:0]  flags_acc;
  logic [1:0]  flags_clr = '0;
  logic        busy;

  int checks = 0;
  int fails  = 0;
  int accepted;

  always #5 clk = ~clk;

  fma16_sched #(.NREQ(NREQ)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_op(req_op), .req_rm(req_rm),
    .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
    .fma_mul(fma_mul), .fma_add(fma_add), .fma_negp(fma_negp), .fma_negz(fma_negz),
    .fma_rm(fma_rm), .fma_result(fma_result), .fma_flags(fma_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .flags_acc(flags_acc), .flags_clr(flags_clr), .busy(busy)
  );

  // Stand-in datapath: 2.0*3.0=6.0 exactly; otherwise echo x and report z[3:0] as flags.
  always_comb begin
    fma_result = fma_x;
    fma_flags  = fma_z[3:0];
    if (fma_mul && !fma_add && fma_x == 16'h4000 && fma_y == 16'h4200) begin
      fma_result = 16'h4600;
      fma_flags  = 4'b0000;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z, input logic [3:0] op);
    req_x[16*i +: 16] = x;
    req_y[16*i +: 16] = y;
    req_z[16*i +: 16] = z;
    req_op[4*i +: 4]  = op;
    req_rm[2*i +: 2]  = 2'b00;
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_fma_x", 32'(fma_x), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_result", 32'(rsp_result), 32'h0);
    check("rst_flags_acc", 32'(flags_acc), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    step();

    // Round-robin from reset: grants 0,1,0,1, responses one cycle later
    set_req(0, 16'h1110, 16'h0, 16'h0, 4'b0100);
    set_req(1, 16'h2220, 16'h0, 16'h0, 4'b0100);
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_gnt%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
      if (k > 0) begin
        check($sformatf("rr_id%0d", k - 1), 32'(rsp_id), 32'((k - 1) % 2));
        check($sformatf("rr_res%0d", k - 1), 32'(rsp_result),
              ((k - 1) % 2 == 0) ? 32'h1110 : 32'h2220);
      end
    end
    req_valid = 2'b00;
    step();
    check("rr_id3", 32'(rsp_id), 32'h1);
    check("rr_res3", 32'(rsp_result), 32'h2220);
    step();
    check("rr_drain_busy", 32'(busy), 32'h0);

    // Single multiply 2.0 * 3.0 from requester 0
    set_req(0, 16'h4000, 16'h4200, 16'h0, 4'b1000);
    req_valid = 2'b01;
    #1;
    check("mul_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    check("mul_fma_x", 32'(fma_x), 32'h4000);
    check("mul_fma_y", 32'(fma_y), 32'h4200);
    check("mul_fma_mul", 32'(fma_mul), 32'h1);
    check("mul_no_rsp_yet", 32'(rsp_valid), 32'h0);
    step();
    check("mul_rsp_valid", 32'(rsp_valid), 32'h1);
    check("mul_rsp_result", 32'(rsp_result), 32'h4600);
    check("mul_rsp_flags", 32'(rsp_flags), 32'h0);
    check("mul_rsp_id", 32'(rsp_id), 32'h0);
    step();
    check("mul_done_valid", 32'(rsp_valid), 32'h0);

    // Backpressure: five cycles of rsp_ready low, exactly two accepted
    rsp_ready = 1'b0;
    accepted  = 0;
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      set_req(0, 16'h0101 + 16'(k), 16'h0, 16'h0, 4'b0100);
      #1;
      check($sformatf("bp_ready%0d", k), 32'(req_ready), (k < 2) ? 32'h1 : 32'h0);
      if (req_ready[0]) accepted++;
      if (k >= 2) begin
        check($sformatf("bp_hold_v%0d", k), 32'(rsp_valid), 32'h1);
        check($sformatf("bp_hold_r%0d", k), 32'(rsp_result), 32'h0101);
      end
      step();
    end
    check("bp_accepted", 32'(accepted), 32'd2);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    #1;
    check("bp_first", 32'(rsp_result), 32'h0101);
    step();
    check("bp_second_v", 32'(rsp_valid), 32'h1);
    check("bp_second", 32'(rsp_result), 32'h0102);
    step();
    check("bp_empty", 32'(rsp_valid), 32'h0);

    // Sticky flags on requester 1
    set_req(1, 16'h0333, 16'h0, 16'h0001, 4'b0100);
    req_valid = 2'b10;
    step();
    set_req(1, 16'h0334, 16'h0, 16'h0004, 4'b0100);
    step();
    req_valid = 2'b00;
    step();
    check("flag_acc_nx", 32'(flags_acc[7:4]), 32'h1);
    step();
    check("flag_acc_sticky", 32'(flags_acc[7:4]), 32'h5);
    check("flag_acc_r0", 32'(flags_acc[3:0]), 32'h0);
    flags_clr = 2'b10;
    step();
    flags_clr = 2'b00;
    check("flag_clr_alone", 32'(flags_acc[7:4]), 32'h0);
    set_req(1, 16'h0335, 16'h0, 16'h0005, 4'b0100);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    check("flag_rsp_flags", 32'(rsp_flags), 32'h5);
    step();
    set_req(1, 16'h0336, 16'h0, 16'h0001, 4'b0100);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    flags_clr = 2'b10;
    step();
    flags_clr = 2'b00;
    check("flag_clr_same_cycle", 32'(flags_acc[7:4]), 32'h1);

    // Reset while both stages are full
    rsp_ready = 1'b0;
    set_req(0, 16'hAAAA, 16'h0, 16'h0002, 4'b0100);
    req_valid = 2'b01;
    step();
    step();
    check("mid_busy", 32'(busy), 32'h1);
    check("mid_rsp_valid", 32'(rsp_valid), 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_fma_x", 32'(fma_x), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_acc", 32'(flags_acc), 32'h0);
    check("mid_rst_result", 32'(rsp_result), 32'h0);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    #3;
    reset_n = 1'b1;
    step();
    check("post_rst_quiet", 32'(rsp_valid), 32'h0);
    set_req(1, 16'h5555, 16'h0, 16'h0, 4'b0100);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    check("post_rst_valid", 32'(rsp_valid), 32'h1);
    check("post_rst_result", 32'(rsp_result), 32'h5555);
    check("post_rst_id", 32'(rsp_id), 32'h1);

    // Idle
    step();
    step();
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_fma_x", 32'(fma_x), 32'h0);
    check("idle_fma_ctl", 32'({fma_mul, fma_add, fma_negp, fma_negz, fma_rm}), 32'h0);
    check("idle_ready", 32'(req_ready), 32'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
